lfsr_checker: RTL
=================

# lfsr_checker

Receive-side companion to the LFSR pattern generator: it takes the NUM_BITS-wide word stream produced by an XNOR-feedback LFSR, self-synchronises to it, then flywheels its own prediction and flags and counts every mismatching word. It sits at the consumer end of any path carrying LFSR data (link/BIST checks, pseudo-random sequence verification) and reports lock state and a saturating error count.

## Interface
- NUM_BITS, 11, word/LFSR width, legal 3..32
- LOCK_CNT, 8, consecutive correct predictions in HUNT needed to declare lock (1..255)
- UNLOCK_CNT, 4, consecutive mispredictions in LOCKED that drop lock (1..255)
- ERR_W, 16, width of error and word counters
- i_Clk  in  1  clock, all logic on rising edge
- i_Rst  in  1  reset, synchronous, active-high
- i_Valid  in  1  i_Data carries a word this cycle
- i_Data  in  NUM_BITS  received LFSR word
- i_Clear_Count  in  1  synchronous clear of o_Err_Count and o_Word_Count
- o_Locked  out  1  checker synchronised
- o_Error  out  1  one-cycle pulse: sampled word mismatched while LOCKED
- o_Sync_Loss  out  1  one-cycle pulse: LOCKED -> HUNT transition
- o_Err_Count  out  ERR_W  saturating count of mismatches while LOCKED
- o_Word_Count  out  ERR_W  saturating count of words checked while LOCKED

## Operation
- Next-word function nxt(w) = {w[N-1:1], fb} (bits numbered N..1), fb = XNOR of taps per XAPP052 table, identical to the generator: e.g. 3:{3,2}, 8:{8,6,5,4}, 11:{11,9}, 16:{16,15,13,4}, 32:{32,22,2,1}. All-ones is the XNOR lock-up state and is never a legal word.
- Internal: r_Exp (predicted word), r_Have (r_Exp valid), r_Match (8 b), r_Miss (8 b), state HUNT/LOCKED.
- Cycles with i_Valid=0: no state change, no pulses.
- HUNT, on valid word w:
  - w all-ones -> r_Have<=0, r_Match<=0.
  - else if r_Have and w==r_Exp -> r_Match+1; else r_Match<=0.
  - r_Exp<=nxt(w), r_Have<=1 (re-seed from received data every word).
  - When incremented r_Match reaches LOCK_CNT -> LOCKED, r_Miss<=0.
  - No error pulses or counting in HUNT.
- LOCKED, on valid word w:
  - r_Exp<=nxt(r_Exp) (flywheel; received data never re-seeds, so a single corrupted word costs exactly one error).
  - o_Word_Count+1 (saturate at all-ones).
  - w!=r_Exp -> o_Error pulse, o_Err_Count+1 (saturate), r_Miss+1; when r_Miss reaches UNLOCK_CNT -> HUNT, r_Have<=0, r_Match<=0, o_Sync_Loss pulse.
  - w==r_Exp -> r_Miss<=0.
- i_Clear_Count: clears both counters; wins over a same-cycle increment (result 0). Does not affect lock state.
- Reset: state HUNT, r_Have=0, r_Match=r_Miss=0, r_Exp=0; o_Locked=0, o_Error=0, o_Sync_Loss=0, o_Err_Count=0, o_Word_Count=0.

## Timing
- All outputs registered; effect of a word sampled at edge k visible after edge k (one-cycle latency).
- o_Locked rises on the edge sampling the LOCK_CNT-th consecutive match; first word checked in LOCKED is the next valid word.
- o_Locked falls and o_Sync_Loss pulses on the same edge as the UNLOCK_CNT-th consecutive o_Error; that word is counted.
- o_Error/o_Sync_Loss high for exactly one cycle per event, even with back-to-back valid words.
- i_Rst mid-stream: everything returns to reset values on that edge; i_Valid ignored while i_Rst=1.
- Sustained throughput: one word per clock, no backpressure.

## Test plan
- NUM_BITS=11, LOCK_CNT=4: after reset feed 0x000,0x001,0x003,0x007,0x00F -> o_Locked=1 one cycle after 0x00F sampled, o_Err_Count=0.
- Locked, 1000 correct words, word 500 bit-flipped -> exactly one o_Error pulse, o_Err_Count=1, o_Word_Count=1000, lock held.
- Locked, UNLOCK_CNT=4, feed 4 consecutive wrong words -> 4 o_Error pulses, o_Sync_Loss and o_Locked=0 on 4th, o_Err_Count=4; 3 wrong then 1 good -> stays locked.
- HUNT fed 0x7FF repeatedly, then valid sequence -> no lock until LOCK_CNT matches after first non-all-ones word.
- ERR_W=4, force 20 errors (UNLOCK_CNT large) -> o_Err_Count saturates 15; i_Clear_Count coincident with error -> count 0.
- Assert i_Rst mid-lock with i_Valid=1 -> all outputs 0 next cycle; relock requires full LOCK_CNT.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker
// Receive-side checker for a word stream produced by an XNOR-feedback LFSR.
// It hunts for the sequence by re-seeding its prediction from each received
// word, declares lock after LOCK_CNT consecutive correct predictions, then
// flywheels its own prediction and flags/counts every mismatching word.
//
// Ports:
//   i_Clk          clock, all logic on the rising edge
//   i_Rst          synchronous active-high reset
//   i_Valid        i_Data carries a word this cycle
//   i_Data         received LFSR word (NUM_BITS)
//   i_Clear_Count  synchronous clear of both counters (wins over increment)
//   o_Locked       checker synchronised
//   o_Error        one-cycle pulse: word mismatched while locked
//   o_Sync_Loss    one-cycle pulse: locked -> hunt transition
//   o_Err_Count    saturating count of mismatches while locked (ERR_W)
//   o_Word_Count   saturating count of words checked while locked (ERR_W)
module lfsr_checker #(
  parameter int NUM_BITS   = 11,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Valid,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clear_Count,
  output logic                o_Locked,
  output logic                o_Error,
  output logic                o_Sync_Loss,
  output logic [ERR_W-1:0]    o_Err_Count,
  output logic [ERR_W-1:0]    o_Word_Count
);

  // One-hot bit for 1-based tap position p.
  function automatic logic [NUM_BITS-1:0] tap(input int p);
    return NUM_BITS'(1) << (p - 1);
  endfunction

  // XAPP052 maximal-length tap sets, identical to the generator side.
  function automatic logic [NUM_BITS-1:0] tap_mask(input int n);
    logic [NUM_BITS-1:0] m;
    case (n)
      3:  m = tap(3)  | tap(2);
      4:  m = tap(4)  | tap(3);
      5:  m = tap(5)  | tap(3);
      6:  m = tap(6)  | tap(5);
      7:  m = tap(7)  | tap(6);
      8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:  m = tap(9)  | tap(5);
      10: m = tap(10) | tap(7);
      11: m = tap(11) | tap(9);
      12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
      13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
      14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
      15: m = tap(15) | tap(14);
      16: m = tap(16) | tap(15) | tap(13) | tap(4);
      17: m = tap(17) | tap(14);
      18: m = tap(18) | tap(11);
      19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
      20: m = tap(20) | tap(17);
      21: m = tap(21) | tap(19);
      22: m = tap(22) | tap(21);
      23: m = tap(23) | tap(18);
      24: m = tap(24) | tap(23) | tap(22) | tap(17);
      25: m = tap(25) | tap(22);
      26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
      27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
      28: m = tap(28) | tap(25);
      29: m = tap(29) | tap(27);
      30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
      31: m = tap(31) | tap(28);
      32: m = tap(32) | tap(22) | tap(2)  | tap(1);
      default: m = tap(n) | tap(n - 1);
    endcase
    return m;
  endfunction

  localparam logic [NUM_BITS-1:0] TAPS     = tap_mask(NUM_BITS);
  localparam logic [7:0]          LOCK_C   = 8'(LOCK_CNT);
  localparam logic [7:0]          UNLOCK_C = 8'(UNLOCK_CNT);
  localparam logic [ERR_W-1:0]    CNT_ONE  = ERR_W'(1);

  // Shift toward the MSB; XNOR of the taps enters at the LSB.
  function automatic logic [NUM_BITS-1:0] nxt(input logic [NUM_BITS-1:0] w);
    return {w[NUM_BITS-2:0], ~^(w & TAPS)};
  endfunction

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] exp_q, exp_d;
  logic                have_q, have_d;
  logic [7:0]          match_q, match_d, match_inc;
  logic [7:0]          miss_q, miss_d, miss_inc;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0]    word_cnt_q, word_cnt_d;
  logic                error_q, error_d;
  logic                sync_loss_q, sync_loss_d;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      have_q      <= 1'b0;
      match_q     <= '0;
      miss_q      <= '0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
      error_q     <= 1'b0;
      sync_loss_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      have_q      <= have_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
      error_q     <= error_d;
      sync_loss_q <= sync_loss_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    have_d      = have_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;
    error_d     = 1'b0;
    sync_loss_d = 1'b0;
    match_inc   = match_q + 8'd1;
    miss_inc    = miss_q + 8'd1;

    if (i_Valid) begin
      case (state_q)
        HUNT: begin
          if (&i_Data) begin
            // All-ones is the XNOR lock-up word: it can never be part of
            // the sequence, so discard any partial synchronisation.
            have_d  = 1'b0;
            match_d = '0;
          end else begin
            exp_d  = nxt(i_Data);
            have_d = 1'b1;
            if (have_q && (i_Data == exp_q)) begin
              match_d = match_inc;
              if (match_inc == LOCK_C) begin
                state_d = LOCKED;
                miss_d  = '0;
              end
            end else begin
              match_d = '0;
            end
          end
        end
        LOCKED: begin
          // Flywheel: the prediction never re-seeds from received data,
          // so one corrupted word costs exactly one error.
          exp_d = nxt(exp_q);
          if (!(&word_cnt_q)) word_cnt_d = word_cnt_q + CNT_ONE;
          if (i_Data != exp_q) begin
            error_d = 1'b1;
            if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_ONE;
            miss_d = miss_inc;
            if (miss_inc == UNLOCK_C) begin
              state_d     = HUNT;
              have_d      = 1'b0;
              match_d     = '0;
              sync_loss_d = 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (i_Clear_Count) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  assign o_Locked     = (state_q == LOCKED);
  assign o_Error      = error_q;
  assign o_Sync_Loss  = sync_loss_q;
  assign o_Err_Count  = err_cnt_q;
  assign o_Word_Count = word_cnt_q;

endmodule
